slv_rst_ctrl: RTL and testbench
===============================

Name: slv_rst_ctrl

Overview:
- Reset responder for the subordinate reset handshake: receives the guard's reset request and answers with reset status.
- Fences the protected subordinate, waits for it to drain, and pulses its reset for a fixed time.
- Waits for the subordinate to settle, then acknowledges with a four-phase req/stat handshake.
- Sits next to the AXI guard: rst_req_i connects to the guard's rst_req_o, and rst_stat_o connects to its rst_stat_i.

Parameters:
- HoldCycles, 16: cycles slv_rst_no is held low; must be >= 1.
- SettleCycles, 8: cycles after reset release before acknowledging; must be >= 1.
- DrainTimeout, 1024: maximum ISOLATE cycles; used only with the optional feature.
- CntWidth, 8: width of the completed-reset counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- rst_req_i  in  1  reset request from guard (level).
- rst_stat_o  out  1  reset-complete status to guard.
- slv_idle_i  in  1  subordinate has no outstanding transactions.
- isolate_o  out  1  fence new AXI requests toward the subordinate.
- slv_rst_no  out  1  active-low reset to the subordinate; registered.
- busy_o  out  1  sequence in progress (any state except IDLE).
- drain_to_o  out  1  sticky: last drain ended by timeout.
- rst_cnt_o  out  CntWidth  completed resets, saturating.

Behaviour:
- All outputs are registered except busy_o, which is a decode of state.
- Reset (rst_ni low, async):
  - state=IDLE, isolate_o=0, rst_stat_o=0, drain_to_o=0, rst_cnt_o=0.
  - slv_rst_no=0, so the subordinate resets with the system.
  - slv_rst_no rises on the first clk_i edge after rst_ni deasserts.
- Single counter `cnt`, sized for max(HoldCycles, SettleCycles, DrainTimeout).
- IDLE:
  - rst_req_i=1 -> ISOLATE next cycle; isolate_o=1 from that cycle; cnt=0; drain_to_o cleared.
- ISOLATE:
  - slv_idle_i=1 -> ASSERT next cycle.
  - The slv_idle_i=1 check is made in the first ISOLATE cycle, so minimum ISOLATE residency is 1 cycle.
- ASSERT:
  - slv_rst_no=0 for exactly HoldCycles cycles, then RELEASE.
- RELEASE:
  - slv_rst_no=1, isolate_o stays 1, for exactly SettleCycles cycles, then DONE.
- DONE:
  - On entry: isolate_o=0, rst_stat_o=1, rst_cnt_o += 1 (holds at all-ones).
  - Stays while rst_req_i=1.
  - rst_req_i=0 -> IDLE; rst_stat_o=0 the following cycle.
- Handshake rules:
  - Four-phase: req up, stat up, req down, stat down.
  - A new request is accepted only after rst_stat_o has returned to 0 in IDLE.
- Latency: rst_req_i rise to rst_stat_o rise = 1 + ISOLATE residency + HoldCycles + SettleCycles cycles.
  - Example: idle subordinate with defaults = 1 + 1 + 16 + 8 = 26 cycles.
- Boundary conditions:
  - rst_req_i dropped mid-sequence: ignored; the sequence completes, DONE sees rst_req_i=0, and rst_stat_o is high for exactly 1 cycle.
  - slv_idle_i toggling during ASSERT/RELEASE: ignored.
  - rst_ni asserted mid-sequence: immediate return to reset values; slv_rst_no=0 asynchronously.
  - rst_cnt_o at saturation: holds all-ones on further resets.

Optional Feature:
- Macro SLV_RST_CTRL_DRAIN_TIMEOUT_EN.
- Defined:
  - ISOLATE also exits to ASSERT when cnt reaches DrainTimeout-1 with slv_idle_i still 0, i.e. after DrainTimeout cycles.
  - On that exit drain_to_o=1, held until the next IDLE->ISOLATE transition.
  - slv_idle_i=1 in the same cycle as timeout takes priority: normal exit, drain_to_o stays 0.
- Undefined:
  - ISOLATE waits indefinitely for slv_idle_i.
  - drain_to_o is tied to 0.

Test Plan:
- Reset values:
  - Hold rst_ni low -> slv_rst_no=0, rst_stat_o=0, isolate_o=0, rst_cnt_o=0.
  - Release rst_ni -> slv_rst_no=1 after the first edge.
- Basic handshake (defaults):
  - rst_req_i=1 with slv_idle_i=1 -> isolate_o at +1, slv_rst_no low for exactly 16 cycles, rst_stat_o=1 at +26, rst_cnt_o=1.
  - Drop rst_req_i -> rst_stat_o=0 one cycle later.
- Drain wait:
  - slv_idle_i=0 for 40 cycles after request -> slv_rst_no stays 1 and isolate_o stays 1 during the wait.
  - Reset asserts the cycle after slv_idle_i rises.
- Early request drop:
  - rst_req_i pulsed for 1 cycle -> full sequence still runs.
  - rst_stat_o high for exactly 1 cycle, then busy_o=0.
- Timeout (macro defined, DrainTimeout=1024):
  - slv_idle_i stuck 0 -> ASSERT after 1024 ISOLATE cycles, drain_to_o=1.
  - Next request clears drain_to_o.
  - Without the macro, the block is still in ISOLATE after 5000 cycles.
- Saturation and mid-sequence reset:
  - CntWidth=2, 5 sequences -> rst_cnt_o=3.
  - rst_ni pulsed low during ASSERT -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/slv_rst_ctrl.sv
// ----------------------------------------------------------------------------
// slv_rst_ctrl
// Reset responder for the subordinate reset handshake. On a request from the
// AXI guard it fences the subordinate, waits for it to drain, pulses its
// reset for HoldCycles, waits SettleCycles, then reports completion with a
// four-phase req/stat handshake.
//
// Optional build macro: SLV_RST_CTRL_DRAIN_TIMEOUT_EN
//   defined   : the drain wait gives up after DrainTimeout cycles and sets
//               drain_to_o.
//   undefined : the drain wait is unbounded and drain_to_o stays 0.
//
// Ports
//   clk_i       in   clock
//   rst_ni      in   asynchronous active-low reset
//   rst_req_i   in   reset request from guard (level)
//   rst_stat_o  out  reset-complete status to guard
//   slv_idle_i  in   subordinate has no outstanding transactions
//   isolate_o   out  fence new AXI requests toward the subordinate
//   slv_rst_no  out  active-low reset to the subordinate
//   busy_o      out  sequence in progress (decode of state)
//   drain_to_o  out  sticky: last drain ended by timeout
//   rst_cnt_o   out  completed resets, saturating
// ----------------------------------------------------------------------------
module slv_rst_ctrl #(
    parameter int unsigned HoldCycles   = 16,
    parameter int unsigned SettleCycles = 8,
    parameter int unsigned DrainTimeout = 1024,
    parameter int unsigned CntWidth     = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                rst_req_i,
    output logic                rst_stat_o,
    input  logic                slv_idle_i,
    output logic                isolate_o,
    output logic                slv_rst_no,
    output logic                busy_o,
    output logic                drain_to_o,
    output logic [CntWidth-1:0] rst_cnt_o
);

    localparam int unsigned MaxHs  = (HoldCycles > SettleCycles) ? HoldCycles : SettleCycles;
    localparam int unsigned MaxCnt = (MaxHs > DrainTimeout) ? MaxHs : DrainTimeout;
    localparam int unsigned CW     = $clog2(MaxCnt + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISOLATE,
        ST_ASSERT,
        ST_RELEASE,
        ST_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  isolate_d;
    logic                  slv_rst_n_d;
    logic                  stat_d;
    logic                  drain_to_d;
    logic [CntWidth-1:0]   rst_cnt_d;

    // Next-state, shared counter and next values of the registered outputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        drain_to_d = drain_to_o;
        rst_cnt_d  = rst_cnt_o;

        case (state_q)
            ST_IDLE: begin
                if (rst_req_i) begin
                    state_d    = ST_ISOLATE;
                    cnt_d      = '0;
                    drain_to_d = 1'b0;
                end
            end

            ST_ISOLATE: begin
                // Idle wins over a coincident timeout
                if (slv_idle_i) begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                end
`ifdef SLV_RST_CTRL_DRAIN_TIMEOUT_EN
                else if (cnt_q == CW'(DrainTimeout - 1)) begin
                    state_d    = ST_ASSERT;
                    cnt_d      = '0;
                    drain_to_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end

            ST_ASSERT: begin
                if (cnt_q == CW'(HoldCycles - 1)) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_RELEASE: begin
                if (cnt_q == CW'(SettleCycles - 1)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    if (rst_cnt_o != '1) begin
                        rst_cnt_d = rst_cnt_o + CntWidth'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_DONE: begin
                if (!rst_req_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered decodes of the next state
        isolate_d   = (state_d == ST_ISOLATE) || (state_d == ST_ASSERT) ||
                      (state_d == ST_RELEASE);
        slv_rst_n_d = (state_d != ST_ASSERT);
        stat_d      = (state_d == ST_DONE);
    end

    // State, counter and output registers; subordinate held in reset with us
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            isolate_o  <= 1'b0;
            slv_rst_no <= 1'b0;
            rst_stat_o <= 1'b0;
            drain_to_o <= 1'b0;
            rst_cnt_o  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            isolate_o  <= isolate_d;
            slv_rst_no <= slv_rst_n_d;
            rst_stat_o <= stat_d;
            drain_to_o <= drain_to_d;
            rst_cnt_o  <= rst_cnt_d;
        end
    end

    assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_slv_rst_ctrl.sv
// ----------------------------------------------------------------------------
// tb_slv_rst_ctrl
// Directed bench for slv_rst_ctrl (CntWidth=2 so saturation is reachable).
// Expected values go into a scoreboard queue when stimulus is applied and are
// popped and compared when the corresponding output is observed.
// Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_slv_rst_ctrl;

    localparam int unsigned CntW = 2;

    logic            clk_i;
    logic            rst_ni;
    logic            rst_req_i;
    logic            rst_stat_o;
    logic            slv_idle_i;
    logic            isolate_o;
    logic            slv_rst_no;
    logic            busy_o;
    logic            drain_to_o;
    logic [CntW-1:0] rst_cnt_o;

    slv_rst_ctrl #(
        .HoldCycles   (16),
        .SettleCycles (8),
        .DrainTimeout (1024),
        .CntWidth     (CntW)
    ) u_dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rst_req_i  (rst_req_i),
        .rst_stat_o (rst_stat_o),
        .slv_idle_i (slv_idle_i),
        .isolate_o  (isolate_o),
        .slv_rst_no (slv_rst_no),
        .busy_o     (busy_o),
        .drain_to_o (drain_to_o),
        .rst_cnt_o  (rst_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   exp_cnt = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL sb_empty: observed %0d with no expected value", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                fails++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Bounded wait for rst_stat_o; counts reset-low and fence-gap cycles
    task automatic wait_stat(output int lat, output int low, output int iso_bad);
        lat = 0;
        low = 0;
        iso_bad = 0;
        while (rst_stat_o !== 1'b1 && lat < 6000) begin
            @(negedge clk_i);
            lat++;
            if (slv_rst_no === 1'b0) low++;
            if (rst_stat_o !== 1'b1 && isolate_o !== 1'b1) iso_bad++;
        end
    endtask

    function automatic void bump_cnt();
        if (exp_cnt < (1 << CntW) - 1) exp_cnt++;
    endfunction

    // Complete a sequence with an idle subordinate and return to IDLE
    task automatic full_seq(input string tag);
        int lat, low, iso_bad;
        rst_req_i  = 1'b1;
        slv_idle_i = 1'b1;
        bump_cnt();
        push({tag, "_lat"}, 32'd26);
        push({tag, "_cnt"}, 32'(exp_cnt));
        wait_stat(lat, low, iso_bad);
        chk(32'(lat));
        chk(32'(rst_cnt_o));
        rst_req_i = 1'b0;
        cyc(1);
    endtask

    initial begin
        int lat, low, iso_bad, hi, k, viol;

        rst_ni     = 1'b0;
        rst_req_i  = 1'b0;
        slv_idle_i = 1'b1;

        // Reset values
        cyc(3);
        push("rst_slv_rst_n", 32'd0);
        push("rst_stat", 32'd0);
        push("rst_isolate", 32'd0);
        push("rst_cnt", 32'd0);
        push("rst_busy", 32'd0);
        push("rst_drain_to", 32'd0);
        chk(32'(slv_rst_no));
        chk(32'(rst_stat_o));
        chk(32'(isolate_o));
        chk(32'(rst_cnt_o));
        chk(32'(busy_o));
        chk(32'(drain_to_o));

        rst_ni = 1'b1;
        push("slv_rst_n_before_edge", 32'd0);
        push("slv_rst_n_after_edge", 32'd1);
        #1 chk(32'(slv_rst_no));
        cyc(1);
        chk(32'(slv_rst_no));

        // Basic handshake
        rst_req_i  = 1'b1;
        slv_idle_i = 1'b1;
        bump_cnt();
        push("basic_lat", 32'd26);
        push("basic_low", 32'd16);
        push("basic_iso_gap", 32'd0);
        push("basic_cnt", 32'(exp_cnt));
        push("basic_done_iso", 32'd0);
        push("basic_done_drain_to", 32'd0);
        wait_stat(lat, low, iso_bad);
        chk(32'(lat));
        chk(32'(low));
        chk(32'(iso_bad));
        chk(32'(rst_cnt_o));
        chk(32'(isolate_o));
        chk(32'(drain_to_o));
        cyc(3);
        push("basic_stat_held", 32'd1);
        chk(32'(rst_stat_o));
        rst_req_i = 1'b0;
        push("basic_stat_drop", 32'd0);
        push("basic_busy_drop", 32'd0);
        cyc(1);
        chk(32'(rst_stat_o));
        chk(32'(busy_o));

        // Drain wait: subordinate busy for 40 cycles
        rst_req_i  = 1'b1;
        slv_idle_i = 1'b0;
        push("drain_wait_viol", 32'd0);
        viol = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (slv_rst_no !== 1'b1 || isolate_o !== 1'b1) viol++;
        end
        chk(32'(viol));
        slv_idle_i = 1'b1;
        push("drain_rst_next", 32'd0);
        cyc(1);
        chk(32'(slv_rst_no));
        slv_idle_i = 1'b0;
        bump_cnt();
        push("drain_toggle_low", 32'd15);
        push("drain_cnt", 32'(exp_cnt));
        wait_stat(lat, low, iso_bad);
        chk(32'(low));
        chk(32'(rst_cnt_o));
        rst_req_i  = 1'b0;
        slv_idle_i = 1'b1;
        cyc(1);

        // Early request drop
        rst_req_i  = 1'b1;
        slv_idle_i = 1'b1;
        cyc(1);
        rst_req_i = 1'b0;
        bump_cnt();
        push("early_lat", 32'd26);
        push("early_cnt", 32'(exp_cnt));
        push("early_stat_width", 32'd1);
        push("early_busy", 32'd0);
        wait_stat(lat, low, iso_bad);
        chk(32'(lat + 1));
        chk(32'(rst_cnt_o));
        hi = 0;
        while (rst_stat_o === 1'b1 && hi < 100) begin
            hi++;
            @(negedge clk_i);
        end
        chk(32'(hi));
        chk(32'(busy_o));

`ifdef SLV_RST_CTRL_DRAIN_TIMEOUT_EN
        // Drain timeout
        rst_req_i  = 1'b1;
        slv_idle_i = 1'b0;
        push("to_first_low", 32'd1025);
        push("to_drain_to", 32'd1);
        k = 0;
        while (slv_rst_no === 1'b1 && k < 3000) begin
            @(negedge clk_i);
            k++;
        end
        chk(32'(k));
        chk(32'(drain_to_o));
        bump_cnt();
        wait_stat(lat, low, iso_bad);
        rst_req_i = 1'b0;
        cyc(1);
        push("to_sticky", 32'd1);
        chk(32'(drain_to_o));
        rst_req_i  = 1'b1;
        slv_idle_i = 1'b1;
        push("to_cleared", 32'd0);
        cyc(1);
        chk(32'(drain_to_o));
        bump_cnt();
        wait_stat(lat, low, iso_bad);
        rst_req_i = 1'b0;
        cyc(1);
`else
        // No timeout: drain wait is unbounded
        rst_req_i  = 1'b1;
        slv_idle_i = 1'b0;
        push("nto_busy", 32'd1);
        push("nto_isolate", 32'd1);
        push("nto_slv_rst_n", 32'd1);
        push("nto_drain_to", 32'd0);
        cyc(5000);
        chk(32'(busy_o));
        chk(32'(isolate_o));
        chk(32'(slv_rst_no));
        chk(32'(drain_to_o));
        slv_idle_i = 1'b1;
        bump_cnt();
        wait_stat(lat, low, iso_bad);
        rst_req_i = 1'b0;
        cyc(1);
`endif

        // Saturation
        push("sat_before", 32'(exp_cnt));
        chk(32'(rst_cnt_o));
        full_seq("sat5");

        // Mid-sequence reset during ASSERT
        rst_req_i  = 1'b1;
        slv_idle_i = 1'b1;
        push("mid_in_assert", 32'd0);
        cyc(5);
        chk(32'(slv_rst_no));
        #2 rst_ni = 1'b0;
        exp_cnt = 0;
        push("mid_slv_rst_n", 32'd0);
        push("mid_isolate", 32'd0);
        push("mid_stat", 32'd0);
        push("mid_cnt", 32'd0);
        push("mid_busy", 32'd0);
        #1;
        chk(32'(slv_rst_no));
        chk(32'(isolate_o));
        chk(32'(rst_stat_o));
        chk(32'(rst_cnt_o));
        chk(32'(busy_o));
        rst_req_i = 1'b0;
        cyc(1);
        rst_ni = 1'b1;
        push("mid_release", 32'd1);
        cyc(1);
        chk(32'(slv_rst_no));

        // One more sequence after reset restarts the count
        full_seq("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
